fetch_unit: RTL

Instruction fetch stage for the 4-bit 8085-style core. It sits directly upstream of `instruction_register`: it owns the program counter, drives the 4-bit program address, and reads 8-bit opcodes from program memory with a ready handshake. Each fetched byte is presented to the decode/instruction-register stage with a valid/ack handshake. Jumps, the `HLT` opcode and a single maskable interrupt redirect the program counter.

---
 rtl/fetch_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the 4-bit 8085-style core. Owns the program
// counter, reads 8-bit opcodes from program memory with a ready handshake and
// hands each opcode downstream with a valid/ack handshake. Jumps, HLT (8'h76)
// and a single maskable interrupt redirect the PC.
//
// Configuration macro: FETCH_INTR_EN
//   defined   : interrupt logic (IE flag, Intr_Ack, Ret_Addr, HALT exit) built
//   undefined : Intr and Ei ignored, Intr_Ack=0, Ret_Addr=0, HALT left by reset
//
// Ports
//   Clk       in   clock, rising edge
//   Rst       in   synchronous reset, active low
//   Mem_Rd    out  program-memory read strobe
//   Addr_Out  out  program address (current PC)
//   Mem_Data  in   program-memory read data
//   Mem_Rdy   in   read data valid this cycle
//   Inst_Out  out  fetched opcode, stable while Inst_Vld=1
//   Inst_Vld  out  opcode available downstream
//   Inst_Ack  in   downstream consumed the opcode
//   Jmp       in   redirect PC on ack
//   Jmp_Addr  in   jump target
//   Intr      in   interrupt request (level)
//   Ei        in   enable-interrupt pulse
//   Intr_Ack  out  one-cycle pulse when the interrupt is taken
//   Ret_Addr  out  PC saved at interrupt entry
//   Halted    out  core halted
//   Bus_Err   out  one-cycle pulse on memory wait timeout
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [3:0]  RST_VECTOR  = 4'h0,
    parameter logic [3:0]  INTR_VECTOR = 4'hC,
    parameter int unsigned MAX_WAIT    = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    output logic       Mem_Rd,
    output logic [3:0] Addr_Out,
    input  logic [7:0] Mem_Data,
    input  logic       Mem_Rdy,
    output logic [7:0] Inst_Out,
    output logic       Inst_Vld,
    input  logic       Inst_Ack,
    input  logic       Jmp,
    input  logic [3:0] Jmp_Addr,
    input  logic       Intr,
    input  logic       Ei,
    output logic       Intr_Ack,
    output logic [3:0] Ret_Addr,
    output logic       Halted,
    output logic       Bus_Err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [7:0] OP_HLT    = 8'h76;
    // Counter value on the cycle whose low Mem_Rdy completes MAX_WAIT waits.
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

`ifdef FETCH_INTR_EN
    localparam logic INTR_EN = 1'b1;
`else
    localparam logic INTR_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       mem_rd_q, mem_rd_d;
    logic [7:0] inst_q, inst_d;
    logic       vld_q, vld_d;
    logic       intr_ack_q, intr_ack_d;
    logic [3:0] ret_addr_q, ret_addr_d;
    logic       halted_q, halted_d;
    logic       bus_err_q, bus_err_d;
    logic       ie_q, ie_d;
    logic [3:0] wait_q, wait_d;

    logic [3:0] pc_next;
    logic       intr_take;

    // PC after an ack: jump target or the already-incremented PC.
    assign pc_next   = Jmp ? Jmp_Addr : pc_q;
    assign intr_take = INTR_EN & Intr & ie_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        vld_d      = vld_q;
        intr_ack_d = 1'b0;
        ret_addr_d = ret_addr_q;
        bus_err_d  = 1'b0;
        wait_d     = wait_q;
        // Interrupt entry below overrides this, so a coinciding Ei loses.
        ie_d       = INTR_EN & (ie_q | Ei);

        unique case (state_q)
            S_FETCH: begin
                // A read is only in flight once Mem_Rd is actually asserted;
                // the first cycle after reset just raises the strobe.
                if (mem_rd_q) begin
                    if (Mem_Rdy) begin
                        inst_d  = Mem_Data;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 4'd1;
                        wait_d  = 4'd0;
                        state_d = S_HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        // Timeout: flag it and retry the same address.
                        bus_err_d = 1'b1;
                        wait_d    = 4'd0;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
            end

            S_HOLD: begin
                if (Inst_Ack) begin
                    vld_d = 1'b0;
                    if (intr_take) begin
                        // Interrupt beats HLT, so a halt acked here is cancelled.
                        ret_addr_d = pc_next;
                        pc_d       = INTR_VECTOR;
                        intr_ack_d = 1'b1;
                        ie_d       = 1'b0;
                        state_d    = S_FETCH;
                    end else if (inst_q == OP_HLT) begin
                        pc_d    = pc_next;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                if (intr_take) begin
                    ret_addr_d = pc_q;
                    pc_d       = INTR_VECTOR;
                    intr_ack_d = 1'b1;
                    ie_d       = 1'b0;
                    state_d    = S_FETCH;
                end
            end

            default: state_d = S_FETCH;
        endcase

        // Strobe and halt flag are registered copies of the next state.
        mem_rd_d = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RST_VECTOR;
            mem_rd_q   <= 1'b0;
            inst_q     <= 8'h00;
            vld_q      <= 1'b0;
            intr_ack_q <= 1'b0;
            ret_addr_q <= 4'h0;
            halted_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            ie_q       <= 1'b0;
            wait_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_rd_q   <= mem_rd_d;
            inst_q     <= inst_d;
            vld_q      <= vld_d;
            intr_ack_q <= intr_ack_d;
            ret_addr_q <= ret_addr_d;
            halted_q   <= halted_d;
            bus_err_q  <= bus_err_d;
            ie_q       <= ie_d;
            wait_q     <= wait_d;
        end
    end

    assign Mem_Rd   = mem_rd_q;
    assign Addr_Out = pc_q;
    assign Inst_Out = inst_q;
    assign Inst_Vld = vld_q;
    assign Intr_Ack = intr_ack_q;
    assign Ret_Addr = ret_addr_q;
    assign Halted   = halted_q;
    assign Bus_Err  = bus_err_q;

endmodule
